// File: rtl/rgu_rst_seq_if.sv
// ---------------------------------------------------------------------------
// rgu_rst_seq_if : bundle between the reset sequencer and its environment.
//   Inputs to the sequencer (driven by the master side):
//     sys_reset_n   external reset pin, async, active-low
//     sb_wdt_rst_n  SB watchdog reset, async, active-low (full reset)
//     wdt_rst_n     system watchdog resets, async, active-low (stage-1 reset)
//     timer0/1      stage-0 / stage-1 hold lengths
//     status_clr    one-cycle pulse, clears rst_status
//   Outputs from the sequencer (driven by the slave side):
//     stage0_done   SB domain released
//     stage1_done   main system released
//     rst_status    sticky reset-cause bits
//     seq_busy      high while the sequencer is not in RUN
// ---------------------------------------------------------------------------
interface rgu_rst_seq_if #(
  parameter int TMR_W   = 16,
  parameter int NUM_WDT = 4
);
  logic               sys_reset_n;
  logic               sb_wdt_rst_n;
  logic [NUM_WDT-1:0] wdt_rst_n;
  logic [TMR_W-1:0]   timer0;
  logic [TMR_W-1:0]   timer1;
  logic               status_clr;
  logic               stage0_done;
  logic               stage1_done;
  logic [7:0]         rst_status;
  logic               seq_busy;

  modport master (
    output sys_reset_n, sb_wdt_rst_n, wdt_rst_n, timer0, timer1, status_clr,
    input  stage0_done, stage1_done, rst_status, seq_busy
  );

  modport slave (
    input  sys_reset_n, sb_wdt_rst_n, wdt_rst_n, timer0, timer1, status_clr,
    output stage0_done, stage1_done, rst_status, seq_busy
  );
endinterface

// File: rtl/rgu_rst_seq.sv
// ---------------------------------------------------------------------------
// rgu_rst_seq : two-stage reset release sequencer feeding the RGU.
//   Synchronises and debounces the reset pin, synchronises the watchdog
//   requests, then times the release of stage 0 (always-on/SB domain) and
//   stage 1 (main system). Keeps a sticky reset-cause word.
// Ports:
//   clk  block clock
//   rst  synchronous active-high reset (power-good)
//   bus  rgu_rst_seq_if.slave (reset requests, timers, status, done flags)
// ---------------------------------------------------------------------------

// Two-flop synchroniser lane; resets to the deasserted (high) level.
module rgu_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;
endmodule

module rgu_rst_seq #(
  parameter int DEB_CYCLES = 5,
  parameter int TMR_W      = 16,
  parameter int NUM_WDT    = 4
) (
  input logic          clk,
  input logic          rst,
  rgu_rst_seq_if.slave bus
);
  localparam int         NSYNC   = NUM_WDT + 2;
  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1, RUN} state_e;

  // synchronised request levels, all active-low
  typedef struct packed {
    logic [NUM_WDT-1:0] wdt_n;
    logic               sb_n;
    logic               pin_n;
  } req_t;

  req_t req_async, req_sync;

  assign req_async = '{wdt_n: bus.wdt_rst_n, sb_n: bus.sb_wdt_rst_n,
                       pin_n: bus.sys_reset_n};

  logic [NSYNC-1:0] async_vec, sync_vec;
  assign async_vec = req_async;
  assign req_sync  = sync_vec;

  for (genvar i = 0; i < NSYNC; i++) begin : g_sync
    rgu_sync2 u_sync (
      .clk    (clk),
      .rst    (rst),
      .async_i(async_vec[i]),
      .sync_o (sync_vec[i])
    );
  end

  // -------------------------------------------------------------------------
  // Pin debounce: count synced-low cycles, saturate; a high cycle restarts.
  // -------------------------------------------------------------------------
  logic [7:0] deb_q, deb_d;
  logic       ext_rst;

  always_comb begin
    deb_d = deb_q;
    if (req_sync.pin_n)        deb_d = 8'd0;
    else if (deb_q != DEB_MAX) deb_d = deb_q + 8'd1;
  end

  assign ext_rst = (deb_q == DEB_MAX);

  // full resets both stages, part resets stage 1 only
  logic full, part;
  assign full = ext_rst | ~req_sync.sb_n;
  assign part = |(~req_sync.wdt_n);

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] t_lat_q, t_lat_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             busy_q, busy_d;
  logic [7:0]       status_q, status_d;
  logic             cnt_hit;

  assign cnt_hit = (cnt_q == t_lat_q);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      t_lat_q  <= '0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      busy_q   <= 1'b1;
      deb_q    <= 8'd0;
      status_q <= 8'h01;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_lat_q  <= t_lat_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      busy_q   <= busy_d;
      deb_q    <= deb_d;
      status_q <= status_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (full) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = HOLD0;
        HOLD0:   if (cnt_hit) state_d = HOLD1;
        HOLD1:   if (!part && cnt_hit) state_d = RUN;
        RUN:     if (part) state_d = HOLD1;
        default: state_d = IDLE;
      endcase
    end
  end

  // outputs and datapath
  always_comb begin
    cnt_d   = cnt_q;
    t_lat_d = t_lat_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    if (full) begin
      cnt_d = '0;
      s0_d  = 1'b0;
      s1_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          t_lat_d = bus.timer0;
          s0_d    = 1'b0;
          s1_d    = 1'b0;
        end
        HOLD0: begin
          // a watchdog here is ignored: stage 1 is still held anyway
          if (cnt_hit) begin
            s0_d    = 1'b1;
            cnt_d   = '0;
            t_lat_d = bus.timer1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD1, RUN: begin
          if (part) begin
            // restart the stage-1 hold; cnt sits at 0 while part persists
            s1_d    = 1'b0;
            cnt_d   = '0;
            t_lat_d = bus.timer1;
          end else if (state_q == HOLD1) begin
            if (cnt_hit) s1_d  = 1'b1;
            else         cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
    busy_d = (state_d != RUN);
  end

  // -------------------------------------------------------------------------
  // Sticky cause bits: a live source beats a simultaneous clear.
  // -------------------------------------------------------------------------
  logic [7:0] status_set;

  always_comb begin
    status_set                = 8'h00;
    status_set[1]             = ext_rst;
    status_set[2]             = ~req_sync.sb_n;
    status_set[3 +: NUM_WDT]  = ~req_sync.wdt_n;
    status_d = (status_q & ~{8{bus.status_clr}}) | status_set;
  end

  assign bus.stage0_done = s0_q;
  assign bus.stage1_done = s1_q;
  assign bus.rst_status  = status_q;
  assign bus.seq_busy    = busy_q;
endmodule

// File: tb/tb_rgu_rst_seq.sv
module tb_rgu_rst_seq;
  localparam int DEB = 5;
  localparam int TW  = 16;
  localparam int NW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgu_rst_seq_if #(.TMR_W(TW), .NUM_WDT(NW)) bus();

  rgu_rst_seq #(.DEB_CYCLES(DEB), .TMR_W(TW), .NUM_WDT(NW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // stimulus values applied on the next tick
  logic          pin = 1'b1, sbw = 1'b1, clr = 1'b0;
  logic [NW-1:0] wdt = '1;
  logic [TW-1:0] t0 = '0, t1 = '0;

  // reference model: input history, low-run length, release deadlines
  logic          pin_h1, pin_h2, sb_h1, sb_h2;
  logic [NW-1:0] wdt_h1, wdt_h2;
  int            m_run, m_cyc, m_dl, m_phase; // phase 0 idle,1 hold0,2 hold1,3 run
  logic          m_s0, m_s1, m_busy;
  logic [7:0]    m_st;
  logic [10:0]   obs, expv;

  task automatic model_reset();
    pin_h1 = 1'b1; pin_h2 = 1'b1; sb_h1 = 1'b1; sb_h2 = 1'b1;
    wdt_h1 = '1; wdt_h2 = '1;
    m_run = 0; m_cyc = 0; m_dl = 0; m_phase = 0;
    m_s0 = 1'b0; m_s1 = 1'b0; m_busy = 1'b1; m_st = 8'h01;
  endtask

  task automatic model_step();
    logic ext, full, part;
    logic [7:0] set;
    ext  = (m_run >= DEB);
    full = ext || !sb_h2;
    part = (wdt_h2 != '1);
    set = 8'h00;
    set[1] = ext;
    set[2] = !sb_h2;
    for (int i = 0; i < NW; i++) set[3+i] = !wdt_h2[i];
    m_st = (clr ? 8'h00 : m_st) | set;
    if (full) begin
      m_phase = 0; m_s0 = 1'b0; m_s1 = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_dl = m_cyc + int'(t0) + 1;
    end else if (part && m_phase >= 2) begin
      m_phase = 2; m_s1 = 1'b0; m_dl = m_cyc + int'(t1) + 1;
    end else if (m_phase == 1 && m_cyc == m_dl) begin
      m_s0 = 1'b1; m_phase = 2; m_dl = m_cyc + int'(t1) + 1;
    end else if (m_phase == 2 && m_cyc == m_dl) begin
      m_s1 = 1'b1; m_phase = 3;
    end
    m_busy = (m_phase != 3);
    m_run  = pin_h2 ? 0 : m_run + 1;
    pin_h2 = pin_h1; pin_h1 = pin;
    sb_h2  = sb_h1;  sb_h1  = sbw;
    wdt_h2 = wdt_h1; wdt_h1 = wdt;
    m_cyc++;
  endtask

  // apply stimulus, advance one clock, land on the falling edge
  task automatic tick();
    bus.sys_reset_n  = pin;
    bus.sb_wdt_rst_n = sbw;
    bus.wdt_rst_n    = wdt;
    bus.timer0       = t0;
    bus.timer1       = t1;
    bus.status_clr   = clr;
    if (!rst) model_step();
    @(posedge clk);
    @(negedge clk);
    obs  = {bus.stage0_done, bus.stage1_done, bus.seq_busy, bus.rst_status};
    expv = {m_s0, m_s1, m_busy, m_st};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    model_reset();
    total++; if (bus.stage0_done !== 1'b0) begin bad++; $display("FAIL rst_s0 got=%b want=0", bus.stage0_done); end
    total++; if (bus.stage1_done !== 1'b0) begin bad++; $display("FAIL rst_s1 got=%b want=0", bus.stage1_done); end
    total++; if (bus.seq_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", bus.seq_busy); end
    total++; if (bus.rst_status !== 8'h01) begin bad++; $display("FAIL rst_status got=%h want=01", bus.rst_status); end
    rst = 1'b0;
  endtask

  task automatic test_release();
    int r0 = -1, r1 = -1, rb = -1;
    t0 = 16'd3; t1 = 16'd2;
    for (int n = 1; n <= 12; n++) begin
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL rel_model n=%0d got=%h want=%h", n, obs, expv); end
      if (r0 < 0 && bus.stage0_done) r0 = n;
      if (r1 < 0 && bus.stage1_done) r1 = n;
      if (rb < 0 && !bus.seq_busy) rb = n;
    end
    total++; if (r0 !== 5) begin bad++; $display("FAIL rel_s0_rise got=%0d want=5", r0); end
    total++; if (r1 !== 8) begin bad++; $display("FAIL rel_s1_rise got=%0d want=8", r1); end
    total++; if (rb !== 8) begin bad++; $display("FAIL rel_busy_fall got=%0d want=8", rb); end
    total++; if (bus.rst_status !== 8'h01) begin bad++; $display("FAIL rel_status got=%h want=01", bus.rst_status); end
  endtask

  task automatic test_wdt_part();
    int f1 = -1, r1 = -1, s0_low = 0;
    t1 = 16'd4;
    for (int n = 1; n <= 14; n++) begin
      wdt = (n == 1) ? 4'b1011 : 4'b1111;
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL wdt_model n=%0d got=%h want=%h", n, obs, expv); end
      if (!bus.stage0_done) s0_low++;
      if (f1 < 0 && !bus.stage1_done) f1 = n;
      if (f1 > 0 && r1 < 0 && bus.stage1_done) r1 = n;
    end
    total++; if (f1 !== 3) begin bad++; $display("FAIL wdt_s1_fall got=%0d want=3", f1); end
    total++; if (r1 !== 8) begin bad++; $display("FAIL wdt_s1_rise got=%0d want=8", r1); end
    total++; if (s0_low !== 0) begin bad++; $display("FAIL wdt_s0_held got=%0d want=0", s0_low); end
    total++; if (bus.rst_status !== 8'h21) begin bad++; $display("FAIL wdt_status got=%h want=21", bus.rst_status); end
  endtask

  // bounded wait for RUN, model-checked each cycle
  task automatic wait_run(input string tag);
    int n = 0;
    while (bus.seq_busy && n < 200) begin
      tick(); n++;
      total++; if (obs !== expv) begin bad++; $display("FAIL %s_wait_model n=%0d got=%h want=%h", tag, n, obs, expv); end
    end
    total++; if (bus.seq_busy !== 1'b0) begin bad++; $display("FAIL %s_wait_timeout busy=%b want=0", tag, bus.seq_busy); end
  endtask

  task automatic test_debounce();
    int lows = 0, f0 = -1, f1 = -1;
    for (int n = 1; n <= 14; n++) begin
      pin = (n <= 4) ? 1'b0 : 1'b1;
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL deb_short_model n=%0d got=%h want=%h", n, obs, expv); end
      if (!bus.stage0_done || !bus.stage1_done) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL deb_short_glitch got=%0d want=0", lows); end
    for (int n = 1; n <= 10; n++) begin
      pin = 1'b0;
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL deb_long_model n=%0d got=%h want=%h", n, obs, expv); end
      if (f0 < 0 && !bus.stage0_done) f0 = n;
      if (f1 < 0 && !bus.stage1_done) f1 = n;
    end
    total++; if (f0 !== 8) begin bad++; $display("FAIL deb_s0_fall got=%0d want=8", f0); end
    total++; if (f1 !== 8) begin bad++; $display("FAIL deb_s1_fall got=%0d want=8", f1); end
    pin = 1'b1;
    wait_run("deb");
    total++; if (bus.rst_status[1] !== 1'b1) begin bad++; $display("FAIL deb_status_bit1 got=%b want=1", bus.rst_status[1]); end
  endtask

  task automatic test_timer_latch();
    int r0 = -1, r1 = -1;
    t1 = 16'd6;
    for (int n = 1; n <= 30; n++) begin
      sbw = (n == 1) ? 1'b0 : 1'b1;
      t0  = (n >= 5) ? 16'd2 : 16'd10;
      wdt = (n == 18) ? 4'b1101 : 4'b1111;
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL tlat_model n=%0d got=%h want=%h", n, obs, expv); end
      if (n >= 4 && r0 < 0 && bus.stage0_done) r0 = n;
      if (n >= 4 && r1 < 0 && bus.stage1_done) r1 = n;
    end
    total++; if (r0 !== 15) begin bad++; $display("FAIL tlat_s0_rise got=%0d want=15", r0); end
    total++; if (r1 !== 27) begin bad++; $display("FAIL tlat_s1_rise got=%0d want=27", r1); end
  endtask

  task automatic test_full_part();
    for (int n = 1; n <= 4; n++) begin
      sbw = (n == 1) ? 1'b0 : 1'b1;
      wdt = (n == 1) ? 4'b1110 : 4'b1111;
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL fp_model n=%0d got=%h want=%h", n, obs, expv); end
      if (n == 3) begin
        total++; if ({bus.stage0_done, bus.stage1_done, bus.seq_busy} !== 3'b001) begin
          bad++; $display("FAIL fp_outputs got=%b want=001", {bus.stage0_done, bus.stage1_done, bus.seq_busy});
        end
      end
    end
    total++; if (bus.rst_status[3:2] !== 2'b11) begin bad++; $display("FAIL fp_status got=%b want=11", bus.rst_status[3:2]); end
    wait_run("fp");
  endtask

  task automatic test_status_clr();
    for (int n = 1; n <= 10; n++) begin
      pin = 1'b0;
      clr = (n == 8);
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL clr_model n=%0d got=%h want=%h", n, obs, expv); end
      if (n == 8) begin
        total++; if (bus.rst_status !== 8'h02) begin bad++; $display("FAIL clr_with_ext got=%h want=02", bus.rst_status); end
      end
    end
    clr = 1'b0; pin = 1'b1;
    wait_run("clr");
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if (bus.rst_status !== 8'h00) begin bad++; $display("FAIL clr_idle got=%h want=00", bus.rst_status); end
  endtask

  task automatic test_random();
    int pin_left = 0, sb_left = 0;
    int wdt_left [NW];
    for (int i = 0; i < NW; i++) wdt_left[i] = 0;
    for (int n = 1; n <= 3000; n++) begin
      if (pin_left > 0) begin pin = 1'b0; pin_left--; end
      else begin pin = 1'b1; if ($urandom_range(0, 59) == 0) pin_left = $urandom_range(1, 12); end
      if (sb_left > 0) begin sbw = 1'b0; sb_left--; end
      else begin sbw = 1'b1; if ($urandom_range(0, 149) == 0) sb_left = $urandom_range(1, 3); end
      for (int i = 0; i < NW; i++) begin
        if (wdt_left[i] > 0) begin wdt[i] = 1'b0; wdt_left[i]--; end
        else begin wdt[i] = 1'b1; if ($urandom_range(0, 79) == 0) wdt_left[i] = $urandom_range(1, 3); end
      end
      clr = ($urandom_range(0, 49) == 0);
      t0  = TW'($urandom_range(0, 7));
      t1  = TW'($urandom_range(0, 7));
      tick();
      total++; if (obs !== expv) begin bad++; $display("FAIL rand_model n=%0d got=%h want=%h", n, obs, expv); end
    end
    pin = 1'b1; sbw = 1'b1; wdt = '1; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_wdt_part();
    test_debounce();
    test_timer_latch();
    test_full_part();
    test_status_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
